// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcode constants, instruction format
// and the decoded register-specifier bundle.
package decode_stage_pkg;

    localparam int FLD_W = 3;

    localparam logic [4:0] OPC_JAL  = 5'b00110;
    localparam logic [4:0] OPC_JALR = 5'b00111;
    localparam logic [4:0] OPC_ST   = 5'b10000;
    localparam logic [4:0] OPC_SLBI = 5'b10010;
    localparam logic [4:0] OPC_STU  = 5'b10011;
    localparam logic [4:0] OPC_LBI  = 5'b11000;

    typedef enum logic [1:0] {
        T_J  = 2'b00,
        T_I1 = 2'b01,
        T_I2 = 2'b10,
        T_R  = 2'b11
    } itype_e;

    typedef struct packed {
        logic [FLD_W-1:0] rs1;
        logic [FLD_W-1:0] rs2;
        logic [FLD_W-1:0] rd;
        logic             rs1_en;
        logic             rs2_en;
        logic             rd_en;
    } dec_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream valid-ready bundle for the decode stage.
// master is the surrounding pipeline, slave is the stage itself.
interface decode_stage_if #(
    parameter int PC_W  = 16,
    parameter int REG_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_instr;
    logic [1:0]       in_type;
    logic [PC_W-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_instr;
    logic [PC_W-1:0]  out_pc;
    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;
    logic [REG_W-1:0] out_rd;
    logic             out_rs1_en;
    logic             out_rs2_en;
    logic             out_rd_en;

    modport master (
        output in_valid, in_instr, in_type, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
        input  out_rs1, out_rs2, out_rd,
        input  out_rs1_en, out_rs2_en, out_rd_en
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
        output out_rs1, out_rs2, out_rd,
        output out_rs1_en, out_rs2_en, out_rd_en
    );
endinterface

// File: rtl/decode_fields.sv
// Combinational register-specifier extraction per instruction format.
// Unused specifiers come out as zero with their enable low.
module decode_fields
    import decode_stage_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic [15:0] instr_i,
    input  logic [1:0]  type_i,
    output dec_t        dec_o
);
    localparam logic [FLD_W-1:0] LINK = FLD_W'(NREGS - 1);

    logic [4:0]       opc;
    logic [FLD_W-1:0] fa;
    logic [FLD_W-1:0] fb;
    logic [FLD_W-1:0] fc;
    itype_e           t;

    assign opc = instr_i[15:11];
    assign fa  = instr_i[10:8];
    assign fb  = instr_i[7:5];
    assign fc  = instr_i[4:2];
    assign t   = itype_e'(type_i);

    always_comb begin
        dec_o = '0;
        unique case (1'b1)
            (t == T_J): begin
                if (opc == OPC_JAL) begin
                    dec_o.rd    = LINK;
                    dec_o.rd_en = 1'b1;
                end
            end
            (t == T_I1): begin
                dec_o.rs1    = fa;
                dec_o.rs1_en = 1'b1;
                if (opc == OPC_ST || opc == OPC_STU) begin
                    dec_o.rs2    = fb;
                    dec_o.rs2_en = 1'b1;
                end
                // STU writes back its base register; plain ST has no rd
                if (opc == OPC_STU) begin
                    dec_o.rd    = fa;
                    dec_o.rd_en = 1'b1;
                end else if (opc != OPC_ST) begin
                    dec_o.rd    = fb;
                    dec_o.rd_en = 1'b1;
                end
            end
            (t == T_I2): begin
                if (opc != OPC_LBI) begin
                    dec_o.rs1    = fa;
                    dec_o.rs1_en = 1'b1;
                end
                if (opc == OPC_JALR) begin
                    dec_o.rd    = LINK;
                    dec_o.rd_en = 1'b1;
                end else if (opc == OPC_SLBI || opc == OPC_LBI) begin
                    dec_o.rd    = fa;
                    dec_o.rd_en = 1'b1;
                end
            end
            default: begin
                dec_o.rs1    = fa;
                dec_o.rs2    = fb;
                dec_o.rd     = fc;
                dec_o.rs1_en = 1'b1;
                dec_o.rs2_en = 1'b1;
                dec_o.rd_en  = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry output register, busy-bit scoreboard
// for RAW/WAW interlock, and a saturating hazard-stall counter.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int PC_W    = 16,
    parameter int NREGS   = 8,
    parameter int CNT_W   = 16,
    localparam int REG_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    decode_stage_if.slave     io,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);
    dec_t             dec;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             hazard;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      instr_q;
    logic [PC_W-1:0]  pc_q;
    logic [REG_W-1:0] rs1_q, rs2_q, rd_q;
    logic             rs1_en_q, rs2_en_q, rd_en_q;

    decode_fields #(.NREGS(NREGS)) u_fields (
        .instr_i (io.in_instr),
        .type_i  (io.in_type),
        .dec_o   (dec)
    );

    assign rs1 = REG_W'(dec.rs1);
    assign rs2 = REG_W'(dec.rs2);
    assign rd  = REG_W'(dec.rd);

    assign hazard = (dec.rs1_en & busy_q[rs1])
                  | (dec.rs2_en & busy_q[rs2])
                  | (dec.rd_en  & busy_q[rd]);

    assign io.in_ready = !hazard && (!out_valid_q || io.out_ready) && !flush;
    assign accept      = io.in_valid && io.in_ready;

    always_comb begin
        busy_d = busy_q;
        // a flushed instruction never reached writeback, so release its rd
        if (flush && out_valid_q && rd_en_q && !io.out_ready)
            busy_d[rd_q] = 1'b0;
        if (wb_valid)
            busy_d[wb_reg] = 1'b0;
        if (accept && dec.rd_en)
            busy_d[rd] = 1'b1;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (io.out_ready)
            out_valid_d = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (io.in_valid && hazard && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            busy_q      <= '0;
            cnt_q       <= '0;
            instr_q     <= '0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_en_q    <= 1'b0;
            rs2_en_q    <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            if (accept) begin
                instr_q  <= io.in_instr;
                pc_q     <= io.in_pc;
                rs1_q    <= rs1;
                rs2_q    <= rs2;
                rd_q     <= rd;
                rs1_en_q <= dec.rs1_en;
                rs2_en_q <= dec.rs2_en;
                rd_en_q  <= dec.rd_en;
            end
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_instr  = instr_q;
    assign io.out_pc     = pc_q;
    assign io.out_rs1    = rs1_q;
    assign io.out_rs2    = rs2_q;
    assign io.out_rd     = rd_q;
    assign io.out_rs1_en = rs1_en_q;
    assign io.out_rs2_en = rs2_en_q;
    assign io.out_rd_en  = rd_en_q;
    assign stall_cnt     = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a random run
// against a behavioural model of decode, scoreboard and counter.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic        flush;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.PC_W(16), .REG_W(3)) bus ();

    decode_stage #(.PC_W(16), .NREGS(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .io        (bus),
        .wb_valid  (wb_valid),
        .wb_reg    (wb_reg),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    typedef struct {
        int rs1; int rs2; int rd;
        bit e1;  bit e2;  bit ed;
    } mdec_t;

    // Decode straight from the format rules, opcodes as integers
    function automatic mdec_t ref_decode(logic [15:0] w, logic [1:0] ty);
        mdec_t r;
        int opc;
        int a;
        int b;
        int c;
        r = '{default: 0};
        opc = int'(w[15:11]);
        a = int'(w[10:8]);
        b = int'(w[7:5]);
        c = int'(w[4:2]);
        case (ty)
            2'd0: if (opc == 6) begin r.rd = 7; r.ed = 1; end
            2'd1: begin
                r.rs1 = a; r.e1 = 1;
                if (opc == 16 || opc == 19) begin r.rs2 = b; r.e2 = 1; end
                if (opc == 19) begin r.rd = a; r.ed = 1; end
                else if (opc != 16) begin r.rd = b; r.ed = 1; end
            end
            2'd2: begin
                if (opc != 24) begin r.rs1 = a; r.e1 = 1; end
                if (opc == 7) begin r.rd = 7; r.ed = 1; end
                else if (opc == 18 || opc == 24) begin r.rd = a; r.ed = 1; end
            end
            default: begin
                r.rs1 = a; r.rs2 = b; r.rd = c;
                r.e1 = 1; r.e2 = 1; r.ed = 1;
            end
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0;
        bus.in_type   = 2'd0;
        bus.in_pc     = 16'h0;
        bus.out_ready = 1'b1;
        wb_valid      = 1'b0;
        wb_reg        = 3'd0;
        flush         = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.out_valid, bus.out_rd, bus.out_rd_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_out got %b want 0", {bus.out_valid, bus.out_rd, bus.out_rd_en});
        end
        checks++;
        if (dut.busy_q !== 8'h00 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_state busy %h cnt %h want 0", dut.busy_q, stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_r_accept;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hDA8C;
        bus.in_type  = 2'd3;
        bus.in_pc    = 16'h0100;
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0100) begin
            errors++;
            $display("FAIL r_valid got v=%b pc=%h want 1 0100", bus.out_valid, bus.out_pc);
        end
        // 0xDA8C: [10:8]=2, [7:5]=4, [4:2]=3
        checks++;
        if ({bus.out_rs1, bus.out_rs2, bus.out_rd} !== {3'd2, 3'd4, 3'd3}) begin
            errors++;
            $display("FAIL r_fields got %0d %0d %0d want 2 4 3",
                     bus.out_rs1, bus.out_rs2, bus.out_rd);
        end
        checks++;
        if (dut.busy_q !== 8'h08) begin
            errors++;
            $display("FAIL r_busy got %h want 08", dut.busy_q);
        end
    endtask

    task automatic test_hazard;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hDB00;
        bus.in_type  = 2'd3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hz_ready got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL hz_cnt1 got %0d want 1", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL hz_cnt2 got %0d want 2", stall_cnt);
        end
        wb_valid = 1'b1;
        wb_reg   = 3'd3;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hz_wb_same got %b want 0", bus.in_ready);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL hz_release rdy %b cnt %0d want 1 3", bus.in_ready, stall_cnt);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 16'hDB00 || dut.busy_q !== 8'h01) begin
            errors++;
            $display("FAIL hz_accept v %b i %h busy %h want 1 DB00 01",
                     bus.out_valid, bus.out_instr, dut.busy_q);
        end
        wb_valid = 1'b1;
        wb_reg   = 3'd0;
        tick();
        idle();
    endtask

    task automatic test_jal_st;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h3123;
        bus.in_type  = 2'd0;
        tick();
        idle();
        checks++;
        if ({bus.out_rd, bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en} !== {3'd7, 3'b100}) begin
            errors++;
            $display("FAIL jal got rd %0d en %b%b%b want 7 100", bus.out_rd,
                     bus.out_rd_en, bus.out_rs1_en, bus.out_rs2_en);
        end
        checks++;
        if (dut.busy_q !== 8'h80) begin
            errors++;
            $display("FAIL jal_busy got %h want 80", dut.busy_q);
        end
        wb_valid = 1'b1;
        wb_reg   = 3'd7;
        tick();
        idle();
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h8140;
        bus.in_type  = 2'd1;
        tick();
        idle();
        checks++;
        if ({bus.out_rs1, bus.out_rs2, bus.out_rs2_en, bus.out_rd_en, bus.out_rd}
            !== {3'd1, 3'd2, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL st got %0d %0d e2 %b ed %b rd %0d want 1 2 1 0 0", bus.out_rs1,
                     bus.out_rs2, bus.out_rs2_en, bus.out_rd_en, bus.out_rd);
        end
        checks++;
        if (dut.busy_q !== 8'h00) begin
            errors++;
            $display("FAIL st_busy got %h want 00", dut.busy_q);
        end
        tick();
    endtask

    task automatic test_hold_flush;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'hC455;
        bus.in_type   = 2'd2;
        tick();
        checks++;
        if ({bus.out_valid, bus.out_rd, bus.out_rs1_en} !== {1'b1, 3'd4, 1'b0}
            || dut.busy_q !== 8'h10) begin
            errors++;
            $display("FAIL lbi got v %b rd %0d e1 %b busy %h want 1 4 0 10",
                     bus.out_valid, bus.out_rd, bus.out_rs1_en, dut.busy_q);
        end
        bus.in_instr = 16'hD800;
        bus.in_type  = 2'd3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_instr !== 16'hC455) begin
                errors++;
                $display("FAIL hold_%0d rdy %b v %b i %h want 0 1 C455", i,
                         bus.in_ready, bus.out_valid, bus.out_instr);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || dut.busy_q !== 8'h00) begin
            errors++;
            $display("FAIL flush got v %b busy %h want 0 00", bus.out_valid, dut.busy_q);
        end
        idle();
    endtask

    task automatic test_wb_set_wins;
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h9612;
        bus.in_type  = 2'd2;
        wb_valid     = 1'b1;
        wb_reg       = 3'd6;
        tick();
        idle();
        checks++;
        if (dut.busy_q !== 8'h40 || bus.out_rd !== 3'd6) begin
            errors++;
            $display("FAIL wb_set busy %h rd %0d want 40 6", dut.busy_q, bus.out_rd);
        end
        wb_valid = 1'b1;
        wb_reg   = 3'd6;
        tick();
        idle();
    endtask

    task automatic test_random;
        logic [4:0] opcs [6] = '{5'd6, 5'd7, 5'd16, 5'd18, 5'd19, 5'd24};
        bit          mbusy [8];
        bit          mv;
        mdec_t       mh;
        mdec_t       d;
        logic [15:0] mi;
        logic [15:0] mp;
        int          mcnt;
        bit          hz;
        bit          rdy;
        bit          acc;
        logic [7:0]  eb;
        logic [4:0]  opc;
        logic [31:0] rnd;
        do_reset();
        foreach (mbusy[i]) mbusy[i] = 0;
        mv = 0; mcnt = 0; mi = 0; mp = 0;
        mh = '{default: 0};
        for (int n = 0; n < 600; n++) begin
            rnd = $urandom;
            opc = rnd[0] ? opcs[$urandom_range(0, 5)] : rnd[5:1];
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_instr  = {opc, rnd[16:6]};
            bus.in_type   = rnd[18:17];
            bus.in_pc     = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            wb_valid      = ($urandom_range(0, 9) < 4);
            wb_reg        = 3'($urandom_range(0, 7));
            flush         = ($urandom_range(0, 19) == 0);
            d = ref_decode(bus.in_instr, bus.in_type);
            hz = (d.e1 && mbusy[d.rs1]) || (d.e2 && mbusy[d.rs2]) || (d.ed && mbusy[d.rd]);
            rdy = !hz && (!mv || bus.out_ready) && !flush;
            acc = bus.in_valid && rdy;
            #1;
            checks++;
            if (bus.in_ready !== rdy) begin
                errors++;
                $display("FAIL rnd_ready[%0d] got %b want %b", n, bus.in_ready, rdy);
            end
            if (bus.in_valid && hz && mcnt < 65535) mcnt++;
            if (flush && mv && mh.ed && !bus.out_ready) mbusy[mh.rd] = 0;
            if (wb_valid) mbusy[wb_reg] = 0;
            if (acc && d.ed) mbusy[d.rd] = 1;
            if (flush) mv = 0;
            else if (acc) mv = 1;
            else if (bus.out_ready) mv = 0;
            if (acc) begin
                mh = d;
                mi = bus.in_instr;
                mp = bus.in_pc;
            end
            foreach (mbusy[i]) eb[i] = mbusy[i];
            tick();
            checks++;
            if (bus.out_valid !== mv || dut.busy_q !== eb || stall_cnt !== 16'(mcnt)) begin
                errors++;
                $display("FAIL rnd_state[%0d] v %b busy %h cnt %0d want %b %h %0d", n,
                         bus.out_valid, dut.busy_q, stall_cnt, mv, eb, mcnt);
            end
            if (mv) begin
                checks++;
                if ({bus.out_instr, bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd,
                     bus.out_rs1_en, bus.out_rs2_en, bus.out_rd_en}
                    !== {mi, mp, 3'(mh.rs1), 3'(mh.rs2), 3'(mh.rd), mh.e1, mh.e2, mh.ed}) begin
                    errors++;
                    $display("FAIL rnd_out[%0d] i %h rs %0d %0d %0d en %b%b%b want %h %0d %0d %0d %b%b%b",
                             n, bus.out_instr, bus.out_rs1, bus.out_rs2, bus.out_rd,
                             bus.out_rs1_en, bus.out_rs2_en, bus.out_rd_en,
                             mi, mh.rs1, mh.rs2, mh.rd, mh.e1, mh.e2, mh.ed);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'hC455;
        bus.in_type   = 2'd2;
        bus.in_pc     = 16'h0042;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_rd, bus.out_rd_en} !== 37'b0
            || dut.busy_q !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid v %b i %h pc %h rd %0d busy %h want all 0", bus.out_valid,
                     bus.out_instr, bus.out_pc, bus.out_rd, dut.busy_q);
        end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_saturate;
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hDA8C;
        bus.in_type  = 2'd3;
        tick();
        bus.in_instr = 16'hDB00;
        repeat (65534) tick();
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre got %h want FFFE", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_top got %h want FFFF", stall_cnt);
        end
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want FFFF", stall_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL sat_reset got %h want 0", stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        test_reset();
        test_r_accept();
        test_hazard();
        test_jal_st();
        test_hold_flush();
        test_wb_set_wins();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
